// File: rtl/timer_pkg.sv
// ----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the machine timer: register byte offsets, the ctrl
// register bit/field positions, the mtimecmp reset constant, the register
// select enumeration and a helper that packs the ctrl read value.
// ----------------------------------------------------------------------------
package timer_pkg;

   // Register byte offsets (word aligned)
   localparam logic [7:0] OFF_MTIME_LO    = 8'h00;
   localparam logic [7:0] OFF_MTIME_HI    = 8'h04;
   localparam logic [7:0] OFF_MTIMECMP_LO = 8'h08;
   localparam logic [7:0] OFF_MTIMECMP_HI = 8'h0C;
   localparam logic [7:0] OFF_CTRL        = 8'h10;

   // ctrl register layout
   localparam int unsigned CTRL_EN_BIT  = 32'd0;
   localparam int unsigned CTRL_DIV_LSB = 32'd8;
   localparam int unsigned CTRL_DIV_MSB = 32'd15;

   // mtimecmp comes out of reset as all-ones so no interrupt can fire early
   localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      REG_NONE        = 3'd0,
      REG_MTIME_LO    = 3'd1,
      REG_MTIME_HI    = 3'd2,
      REG_MTIMECMP_LO = 3'd3,
      REG_MTIMECMP_HI = 3'd4,
      REG_CTRL        = 3'd5
   } reg_sel_t;

   // Build the 32-bit ctrl read value from its fields
   function automatic logic [31:0] ctrl_pack(input logic en, input logic [7:0] div);
      logic [31:0] v;
      v = 32'h0000_0000;
      v[CTRL_EN_BIT] = en;
      v[CTRL_DIV_MSB:CTRL_DIV_LSB] = div;
      return v;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// ----------------------------------------------------------------------------
// tick_gen
// Prescaler for the machine timer. While en=1 an 8-bit counter runs 0..div
// and tick fires on the cycle the counter equals div (every cycle when
// div=0). While en=0 the counter holds and no tick fires. clear forces the
// counter back to 0.
// Ports:
//   clk   in   clock, rising edge
//   rst_n in   synchronous active-low reset
//   en    in   prescaler enable
//   div   in   8-bit terminal count
//   clear in   synchronous counter clear
//   tick  out  one-cycle increment strobe for mtime
// ----------------------------------------------------------------------------
module tick_gen (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [7:0] div,
   input  logic       clear,
   output logic       tick
);

   logic [7:0] cnt_r;
   logic       hit_s;

   // Terminal-count detect; tick is decoded from registered state only so the
   // mtime increment lands on the same edge the counter wraps.
   always_comb begin
      hit_s = (cnt_r == div);
      tick  = en & hit_s;
   end

   // Prescale counter: clear wins, then count/wrap while enabled, else hold
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= 8'd0;
      end else if (clear) begin
         cnt_r <= 8'd0;
      end else if (en) begin
         if (hit_s) begin
            cnt_r <= 8'd0;
         end else begin
            cnt_r <= cnt_r + 8'd1;
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/machine_timer.sv
// ----------------------------------------------------------------------------
// machine_timer
// 64-bit machine timer (mtime/mtimecmp) behind a simple register port, with a
// programmable prescaler and a registered level timer-interrupt request.
// Register map: 0x00 mtime_lo, 0x04 mtime_hi, 0x08 mtimecmp_lo,
//               0x0C mtimecmp_hi, 0x10 ctrl (bit0 en, bits[15:8] div).
// Reading mtime_lo snapshots mtime[63:32]; reading mtime_hi returns that
// snapshot, making a lo-then-hi read pair coherent.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   bus_sel     in   register access request this cycle
//   bus_we      in   1 = write, 0 = read
//   bus_addr    in   byte address, bits [1:0] ignored
//   bus_wdata   in   write data
//   bus_rdata   out  read data, 0 unless bus_rvalid=1
//   bus_rvalid  out  one-cycle pulse one cycle after a read
//   tm_interupt out  level timer-interrupt request
// ----------------------------------------------------------------------------
module machine_timer
   import timer_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32'd5,
   parameter int unsigned RST_DIV = 32'd0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bus_sel,
   input  logic              bus_we,
   input  logic [ADDR_W-1:0] bus_addr,
   input  logic [31:0]       bus_wdata,
   output logic [31:0]       bus_rdata,
   output logic              bus_rvalid,
   output logic              tm_interupt
);

   logic [63:0]       mtime_r;
   logic [63:0]       mtimecmp_r;
   logic              en_r;
   logic [7:0]        div_r;
   logic [31:0]       shadow_r;
   logic [31:0]       rdata_r;
   logic              rvalid_r;
   logic              irq_r;

   logic [ADDR_W-1:0] aligned_addr_s;
   reg_sel_t          reg_sel_s;
   logic              wr_s;
   logic              rd_s;
   logic              ctrl_wr_s;
   logic              tick_s;
   logic [31:0]       rd_mux_s;
   logic              unused_addr_s;

   assign unused_addr_s = ^bus_addr[1:0];

   // Address decode and read-data selection
   always_comb begin
      aligned_addr_s = {bus_addr[ADDR_W-1:2], 2'b00};
      case (aligned_addr_s)
         ADDR_W'(OFF_MTIME_LO):    reg_sel_s = REG_MTIME_LO;
         ADDR_W'(OFF_MTIME_HI):    reg_sel_s = REG_MTIME_HI;
         ADDR_W'(OFF_MTIMECMP_LO): reg_sel_s = REG_MTIMECMP_LO;
         ADDR_W'(OFF_MTIMECMP_HI): reg_sel_s = REG_MTIMECMP_HI;
         ADDR_W'(OFF_CTRL):        reg_sel_s = REG_CTRL;
         default:                  reg_sel_s = REG_NONE;
      endcase

      wr_s      = bus_sel & bus_we;
      rd_s      = bus_sel & ~bus_we;
      ctrl_wr_s = wr_s & (reg_sel_s == REG_CTRL);

      case (reg_sel_s)
         REG_MTIME_LO:    rd_mux_s = mtime_r[31:0];
         REG_MTIME_HI:    rd_mux_s = shadow_r;
         REG_MTIMECMP_LO: rd_mux_s = mtimecmp_r[31:0];
         REG_MTIMECMP_HI: rd_mux_s = mtimecmp_r[63:32];
         REG_CTRL:        rd_mux_s = ctrl_pack(en_r, div_r);
         default:         rd_mux_s = 32'h0000_0000;
      endcase
   end

   tick_gen u_tick_gen (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_r),
      .div   (div_r),
      .clear (ctrl_wr_s),
      .tick  (tick_s)
   );

   // mtime: a bus write to either half wins over a coincident tick
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtime_r <= 64'd0;
      end else if (wr_s && (reg_sel_s == REG_MTIME_LO)) begin
         mtime_r[31:0] <= bus_wdata;
      end else if (wr_s && (reg_sel_s == REG_MTIME_HI)) begin
         mtime_r[63:32] <= bus_wdata;
      end else if (tick_s) begin
         mtime_r <= mtime_r + 64'd1;
      end else begin
         mtime_r <= mtime_r;
      end
   end

   // mtimecmp and ctrl registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mtimecmp_r <= MTIMECMP_RST;
         en_r       <= 1'b0;
         div_r      <= 8'(RST_DIV);
      end else if (wr_s) begin
         case (reg_sel_s)
            REG_MTIMECMP_LO: mtimecmp_r[31:0]  <= bus_wdata;
            REG_MTIMECMP_HI: mtimecmp_r[63:32] <= bus_wdata;
            REG_CTRL: begin
               en_r  <= bus_wdata[CTRL_EN_BIT];
               div_r <= bus_wdata[CTRL_DIV_MSB:CTRL_DIV_LSB];
            end
            default: begin
               mtimecmp_r <= mtimecmp_r;
            end
         endcase
      end else begin
         mtimecmp_r <= mtimecmp_r;
      end
   end

   // Shadow of mtime[63:32], captured by a read of mtime_lo
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         shadow_r <= 32'h0000_0000;
      end else if (rd_s && (reg_sel_s == REG_MTIME_LO)) begin
         shadow_r <= mtime_r[63:32];
      end else begin
         shadow_r <= shadow_r;
      end
   end

   // Read response: one-cycle rvalid pulse, data forced to 0 otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0000_0000;
      end else if (rd_s) begin
         rvalid_r <= 1'b1;
         rdata_r  <= rd_mux_s;
      end else begin
         rvalid_r <= 1'b0;
         rdata_r  <= 32'h0000_0000;
      end
   end

   // Registered interrupt request: unsigned 64-bit compare gated by en
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq_r <= 1'b0;
      end else begin
         irq_r <= en_r & (mtime_r >= mtimecmp_r);
      end
   end

   assign bus_rdata   = rdata_r;
   assign bus_rvalid  = rvalid_r;
   assign tm_interupt = irq_r;

endmodule

// File: tb/tb_machine_timer.sv
// ----------------------------------------------------------------------------
// tb_machine_timer
// Directed self-checking bench for machine_timer. Inputs are driven on the
// falling edge; outputs are sampled on the falling edge. Cycle k is the
// period ending at the k-th rising edge after a register write is accepted.
// ----------------------------------------------------------------------------
module tb_machine_timer;

   logic        clk;
   logic        rst_n;
   logic        bus_sel;
   logic        bus_we;
   logic [4:0]  bus_addr;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_rvalid;
   logic        tm_interupt;

   int n_checks;
   int n_errors;
   logic [31:0] rd;

   machine_timer #(.ADDR_W(5), .RST_DIV(0)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus_sel     (bus_sel),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_rdata   (bus_rdata),
      .bus_rvalid  (bus_rvalid),
      .tm_interupt (tm_interupt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_errors = n_errors + 1;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One write cycle; returns on the falling edge after the accepting edge
   task automatic bus_write(input logic [4:0] addr, input logic [31:0] data);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
      @(negedge clk);
      bus_sel = 1'b0; bus_we = 1'b0; bus_wdata = 32'h0;
   endtask

   // One read cycle; samples the response while rvalid is high
   task automatic bus_read(input logic [4:0] addr, output logic [31:0] data);
      @(negedge clk);
      bus_sel = 1'b1; bus_we = 1'b0; bus_addr = addr;
      @(negedge clk);
      bus_sel = 1'b0;
      check_val("rvalid_pulse", 64'(bus_rvalid), 64'd1);
      data = bus_rdata;
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      rst_n = 1'b0; bus_sel = 1'b0; bus_we = 1'b0; bus_addr = 5'h00; bus_wdata = 32'h0;
      repeat (2) @(negedge clk);
      check_val("rst_irq",    64'(tm_interupt), 64'd0);
      check_val("rst_rvalid", 64'(bus_rvalid),  64'd0);
      check_val("rst_rdata",  64'(bus_rdata),   64'd0);
      rst_n = 1'b1;

      // Reset register contents
      bus_read(5'h10, rd); check_val("rst_ctrl", 64'(rd), 64'h0);
      bus_read(5'h08, rd); check_val("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
      bus_read(5'h0C, rd); check_val("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
      bus_read(5'h00, rd); check_val("rst_mtime_lo", 64'(rd), 64'h0);
      @(negedge clk);
      check_val("idle_rvalid", 64'(bus_rvalid), 64'd0);
      check_val("idle_rdata",  64'(bus_rdata),  64'd0);

      // Unmapped offsets: read 0, write ignored
      bus_read(5'h14, rd); check_val("unmapped_rd", 64'(rd), 64'h0);
      bus_write(5'h18, 32'hFFFF_FFFF);
      bus_read(5'h10, rd); check_val("unmapped_wr_ctrl", 64'(rd), 64'h0);
      bus_read(5'h08, rd); check_val("unmapped_wr_cmp", 64'(rd), 64'hFFFF_FFFF);

      // Interrupt rises 11 cycles after enable with mtimecmp=10, div=0
      bus_write(5'h08, 32'd10);
      bus_write(5'h0C, 32'd0);
      bus_write(5'h10, 32'h0000_0001);
      repeat (10) @(negedge clk);
      check_val("irq_c11_low", 64'(tm_interupt), 64'd0);
      @(negedge clk);
      check_val("irq_c12_high", 64'(tm_interupt), 64'd1);

      // Raising mtimecmp drops the interrupt two cycles after the write
      bus_write(5'h0C, 32'hFFFF_FFFF);
      check_val("cmpwr_irq_t1", 64'(tm_interupt), 64'd1);
      @(negedge clk);
      check_val("cmpwr_irq_t2", 64'(tm_interupt), 64'd0);

      // mtime_lo write coincident with a tick keeps the written value
      bus_write(5'h00, 32'h0000_0100);
      bus_read(5'h00, rd); check_val("wr_over_tick", 64'(rd), 64'h101);
      bus_read(5'h04, rd); check_val("wr_over_tick_hi", 64'(rd), 64'h0);

      // Clearing en drops the interrupt on the following cycle
      bus_write(5'h0C, 32'd0);
      bus_write(5'h10, 32'h0000_0000);
      check_val("en_clr_irq_t1", 64'(tm_interupt), 64'd1);
      @(negedge clk);
      check_val("en_clr_irq_t2", 64'(tm_interupt), 64'd0);

      // div=3: one increment every 4 cycles, 5 after 20 enabled cycles
      bus_write(5'h00, 32'd0);
      bus_write(5'h04, 32'd0);
      bus_write(5'h10, 32'h0000_0301);
      repeat (19) @(negedge clk);
      bus_write(5'h10, 32'h0000_0300);
      bus_read(5'h00, rd); check_val("div3_mtime_lo", 64'(rd), 64'd5);
      bus_read(5'h04, rd); check_val("div3_mtime_hi", 64'(rd), 64'd0);
      bus_read(5'h10, rd); check_val("div3_ctrl", 64'(rd), 64'h300);

      // 64-bit wrap with mtimecmp all-ones: interrupt only at the all-ones value
      bus_write(5'h08, 32'hFFFF_FFFF);
      bus_write(5'h0C, 32'hFFFF_FFFF);
      bus_write(5'h00, 32'hFFFF_FFFF);
      bus_write(5'h04, 32'hFFFF_FFFF);
      bus_write(5'h10, 32'h0000_0001);
      check_val("wrap_irq_c1", 64'(tm_interupt), 64'd0);
      @(negedge clk);
      check_val("wrap_irq_c2", 64'(tm_interupt), 64'd1);
      @(negedge clk);
      check_val("wrap_irq_c3", 64'(tm_interupt), 64'd0);
      bus_read(5'h00, rd); check_val("wrap_mtime_lo", 64'(rd), 64'd2);
      bus_read(5'h04, rd); check_val("wrap_mtime_hi", 64'(rd), 64'd0);

      // Coherent lo/hi read pair across a carry
      bus_write(5'h10, 32'h0000_0000);
      bus_write(5'h00, 32'hFFFF_FFFF);
      bus_write(5'h04, 32'h0000_0000);
      bus_write(5'h10, 32'h0000_0301);
      bus_read(5'h00, rd); check_val("carry_lo", 64'(rd), 64'hFFFF_FFFF);
      repeat (4) @(negedge clk);
      bus_read(5'h04, rd); check_val("carry_hi_shadow", 64'(rd), 64'd0);
      bus_read(5'h00, rd);
      bus_read(5'h04, rd); check_val("carry_hi_fresh", 64'(rd), 64'd1);

      // Reset mid-count with the interrupt asserted and a read presented
      bus_write(5'h08, 32'd0);
      bus_write(5'h0C, 32'd0);
      repeat (2) @(negedge clk);
      check_val("pre_rst_irq", 64'(tm_interupt), 64'd1);
      rst_n = 1'b0; bus_sel = 1'b1; bus_we = 1'b0; bus_addr = 5'h00;
      @(negedge clk);
      check_val("mid_rst_irq",    64'(tm_interupt), 64'd0);
      check_val("mid_rst_rvalid", 64'(bus_rvalid),  64'd0);
      check_val("mid_rst_rdata",  64'(bus_rdata),   64'd0);
      rst_n = 1'b1; bus_sel = 1'b0;
      @(negedge clk);
      check_val("rst_drop_rvalid", 64'(bus_rvalid), 64'd0);
      bus_read(5'h00, rd); check_val("post_rst_mtime", 64'(rd), 64'd0);
      bus_read(5'h0C, rd); check_val("post_rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
      bus_read(5'h10, rd); check_val("post_rst_ctrl", 64'(rd), 64'h0);
      check_val("post_rst_irq", 64'(tm_interupt), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
